// File: rtl/tc_pkg.sv
// Shared definitions for the memory-mapped timer: FSM states, register offsets and CTRL layout.
package tc_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StCnt  = 2'd2,
        StInt  = 2'd3
    } tc_state_e;

    localparam logic [1:0] CTRL_OFS   = 2'd0;
    localparam logic [1:0] PRESET_OFS = 2'd1;
    localparam logic [1:0] COUNT_OFS  = 2'd2;

    localparam int unsigned CTRL_EN      = 0;
    localparam int unsigned CTRL_MODE_LO = 1;
    localparam int unsigned CTRL_MODE_HI = 2;
    localparam int unsigned CTRL_IM      = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    // Field order matches the CTRL bit positions above (im=3, mode=2:1, en=0).
    typedef struct packed {
        logic       im;
        logic [1:0] mode;
        logic       en;
    } ctrl_t;

endpackage

// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer with one-shot / auto-reload modes and a maskable irq.
module timer_counter
    import tc_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00,
    parameter int unsigned CNT_WIDTH = 32  // must not exceed 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    tc_state_e            state_q, state_d;
    ctrl_t                ctrl_q, ctrl_d;
    logic [CNT_WIDTH-1:0] preset_q, preset_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 pend_q, pend_d;
    logic                 irq_q, irq_d;

    localparam logic [CNT_WIDTH-1:0] CntOne = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic hit, wr_ctrl, wr_preset;
    logic unused_addr;

    assign unused_addr = ^addr[1:0];
    assign hit         = (addr[31:4] == BASE_ADDR[31:4]) && (addr[3:2] != 2'b11);
    assign wr_ctrl     = we && hit && (addr[3:2] == CTRL_OFS);
    assign wr_preset   = we && hit && (addr[3:2] == PRESET_OFS);

    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        preset_d = preset_q;
        count_d  = count_q;
        pend_d   = pend_q;

        unique case (state_q)
            StIdle: begin
                if (ctrl_q.en) state_d = StLoad;
            end
            StLoad: begin
                count_d = preset_q;
                state_d = StCnt;
            end
            StCnt: begin
                if (!ctrl_q.en) begin
                    state_d = StIdle;
                end else if (count_q > CntOne) begin
                    count_d = count_q - CntOne;
                end else begin
                    // Covers PRESET=0 too: saturate at zero rather than wrap.
                    count_d = '0;
                    pend_d  = 1'b1;
                    state_d = StInt;
                end
            end
            StInt: begin
                if (ctrl_q.mode == MODE_RELOAD) begin
                    pend_d  = 1'b0;
                    state_d = StLoad;
                end else begin
                    ctrl_d.en = 1'b0;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Bus writes are applied last so they override the FSM's EN clear and irq_pend set.
        if (wr_ctrl) begin
            ctrl_d = ctrl_t'(wdata[3:0]);
            pend_d = 1'b0;
        end
        if (wr_preset) preset_d = wdata[CNT_WIDTH-1:0];

        irq_d = ctrl_d.im & pend_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            ctrl_q   <= '0;
            preset_q <= '0;
            count_q  <= '0;
            pend_q   <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            pend_q   <= pend_d;
            irq_q    <= irq_d;
        end
    end

    always_comb begin
        rdata = '0;
        if (hit) begin
            unique case (addr[3:2])
                CTRL_OFS:   rdata[3:0]           = ctrl_q;
                PRESET_OFS: rdata[CNT_WIDTH-1:0] = preset_q;
                COUNT_OFS:  rdata[CNT_WIDTH-1:0] = count_q;
                default:    rdata                = '0;
            endcase
        end
    end

    assign irq = irq_q;

endmodule

// File: tb/tb_timer_counter.sv
// Scoreboard bench for timer_counter: a timeline-based reference model predicts rdata/irq per cycle.
module tb_timer_counter;

    localparam logic [31:0] B = 32'h0000_7F00;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] addr = '0;
    logic        we = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        irq;

    timer_counter #(.BASE_ADDR(B), .CNT_WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd;
        logic        irq;
        logic [31:0] a;
        int          phase;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   total = 0;
    int   bad = 0;
    int   phase = 0;

    // Reference model: a run starts on the edge the timer leaves idle; later edges are
    // classified by their distance k from that start (1 = load, then counting, then expiry).
    logic        m_en, m_im, m_pend, m_irq;
    logic [1:0]  m_mode;
    logic [31:0] m_preset, m_count;
    int          edge_no, run_start, period;

    function automatic logic [31:0] exp_read(input logic [31:0] a);
        if (a[31:4] != B[31:4] || a[3:2] == 2'b11) return 32'd0;
        if (a[3:2] == 2'b00) return {28'd0, m_im, m_mode, m_en};
        if (a[3:2] == 2'b01) return m_preset;
        return m_count;
    endfunction

    task automatic model_reset();
        m_en = 0; m_im = 0; m_mode = 0; m_pend = 0; m_irq = 0;
        m_preset = 0; m_count = 0;
        run_start = -1; period = 1;
    endtask

    task automatic model_edge(input logic w, input logic [31:0] a, input logic [31:0] d);
        int k;
        edge_no++;
        if (run_start < 0) begin
            if (m_en) run_start = edge_no;
        end else begin
            k = edge_no - run_start;
            if (k == 1) begin
                m_count = m_preset;
                period  = (m_preset == 0) ? 1 : int'(m_preset);
            end else if (k <= period + 1) begin
                if (!m_en) run_start = -1;
                else if (k == period + 1) begin
                    m_count = 0;
                    m_pend  = 1;
                end else m_count = m_count - 1;
            end else begin
                if (m_mode == 2'b01) begin
                    run_start = edge_no;
                    m_pend    = 0;
                end else begin
                    m_en      = 0;
                    run_start = -1;
                end
            end
        end
        if (w && a[31:4] == B[31:4] && a[3:2] == 2'b00) begin
            {m_im, m_mode, m_en} = d[3:0];
            m_pend = 0;
        end
        if (w && a[31:4] == B[31:4] && a[3:2] == 2'b01) m_preset = d;
        m_irq = m_im & m_pend;
    endtask

    task automatic cycle(input logic w, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        reset = 0; we = w; addr = a; wdata = d;
        exp_q.push_back('{exp_read(a), m_irq, a, phase});
        model_edge(w, a, d);
    endtask

    // Reset is raised mid-cycle so the checks observe the asynchronous clear before any edge.
    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
            reset = 1; we = 0; addr = B + 32'(4 * (i % 3));
            model_reset();
            exp_q.push_back('{exp_read(addr), 1'b0, addr, phase});
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (rdata !== e.rd) begin
                    bad++;
                    $display("FAIL rdata phase=%0d addr=%h got=%h want=%h", e.phase, e.a, rdata, e.rd);
                end
                total++;
                if (irq !== e.irq) begin
                    bad++;
                    $display("FAIL irq phase=%0d addr=%h got=%b want=%b", e.phase, e.a, irq, e.irq);
                end
            end
        end
    end

    initial begin
        logic [31:0] a, d;
        logic        w;
        int          r;
        edge_no = 0;
        model_reset();
        do_reset(3);

        phase = 1;  // one-shot, masked-in irq
        cycle(1, B + 4, 32'd3);
        cycle(1, B + 0, 32'h9);
        for (int i = 0; i < 8; i++) cycle(0, B + 8, 0);
        cycle(0, B + 0, 0);
        cycle(0, B + 0, 0);
        cycle(1, B + 0, 32'h8);
        cycle(0, B + 0, 0);
        cycle(0, B + 8, 0);

        phase = 2;  // auto-reload pulses
        cycle(1, B + 4, 32'd2);
        cycle(1, B + 0, 32'hB);
        for (int i = 0; i < 14; i++) cycle(0, B + 8, 0);
        cycle(1, B + 0, 32'h0);

        phase = 3;  // masked irq, then pause and resume
        cycle(1, B + 0, 32'h1);
        for (int i = 0; i < 6; i++) cycle(0, B + 8, 0);
        cycle(1, B + 4, 32'd6);
        cycle(1, B + 0, 32'h1);
        for (int i = 0; i < 4; i++) cycle(0, B + 8, 0);
        cycle(1, B + 0, 32'h0);
        for (int i = 0; i < 3; i++) cycle(0, B + 8, 0);
        cycle(1, B + 0, 32'h1);
        for (int i = 0; i < 5; i++) cycle(0, B + 8, 0);

        phase = 4;  // bus edge cases
        cycle(1, B + 4, 32'd8);
        cycle(1, B + 0, 32'h9);
        cycle(0, B + 8, 0);
        cycle(0, B + 8, 0);
        cycle(1, B + 8, 32'h55);
        cycle(1, B + 32'hC, 32'hFF);
        cycle(0, B + 32'hC, 0);
        cycle(1, B + 32'h10, 32'h0);
        cycle(1, B ^ 32'h1000_0000, 32'h0);
        cycle(0, B + 32'h10, 0);
        cycle(1, B + 32'h6, 32'd2);
        cycle(0, B + 32'h5, 0);
        for (int i = 0; i < 10; i++) cycle(0, B + 32'hB, 0);

        phase = 5;  // PRESET=0 behaves as 1
        cycle(1, B + 4, 32'd0);
        cycle(1, B + 0, 32'h9);
        for (int i = 0; i < 5; i++) cycle(0, B + 8, 0);

        phase = 6;  // reset mid-count
        cycle(1, B + 4, 32'd100);
        cycle(1, B + 0, 32'h9);
        for (int i = 0; i < 50; i++) cycle(0, B + 8, 0);
        do_reset(3);
        for (int i = 0; i < 4; i++) cycle(0, B + 8, 0);

        phase = 7;  // randomized traffic
        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(0, 9));
            if (r <= 2) a = B;
            else if (r <= 4) a = B + 4;
            else if (r <= 6) a = B + 8;
            else if (r == 7) a = B + 32'hC;
            else if (r == 8) a = $urandom();
            else a = B + 32'(4 * $urandom_range(0, 2)) + 32'($urandom_range(0, 3));
            w = ($urandom_range(0, 3) == 0);
            d = (a[3:2] == 2'b01) ? 32'($urandom_range(0, 6)) : $urandom();
            if ($urandom_range(0, 99) == 0) do_reset(1);
            else cycle(w, a, d);
        end

        @(negedge clk);
        @(negedge clk);
        #5;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
